// File: rtl/mac_lookup_table_pkg.sv
// -----------------------------------------------------------------------------
// mac_lookup_table_pkg
// Shared Ethernet switch definitions for the destination-MAC lookup engine:
// MAC / port-id widths, broadcast address, group-bit position, default flood
// port, the lookup request record carried down the pipeline, and small MAC
// classification helpers.
// -----------------------------------------------------------------------------
package mac_lookup_table_pkg;

  localparam int MAC_W     = 48;
  localparam int PORT_W    = 4;
  localparam int GROUP_BIT = 40;

  localparam logic [MAC_W-1:0]  BCAST_MAC          = 48'hFFFF_FFFF_FFFF;
  localparam logic [PORT_W-1:0] FLOOD_PORT_DEFAULT = 4'd15;

  typedef logic [MAC_W-1:0]  mac_t;
  typedef logic [PORT_W-1:0] port_t;

  // Request record travelling from the grant stage to the compare stage.
  typedef struct packed {
    mac_t  mac;
    port_t id;
  } lkup_req_t;

  // Only unicast, non-zero source addresses may occupy a table entry.
  function automatic logic mac_learnable(input mac_t mac);
    return !mac[GROUP_BIT] && (mac != '0);
  endfunction

  function automatic logic mac_is_bcast(input mac_t mac);
    return mac == BCAST_MAC;
  endfunction

endpackage

// File: rtl/mac_lookup_table_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mac_lookup_table_rr_arbiter
// Round-robin arbiter with a rotating priority pointer. The first requester at
// or after the pointer (cyclically) is granted; the pointer then moves to the
// port just after the winner so it has lowest priority next time.
// Ports:
//   clk_i      in  1            clock
//   rst_ni     in  1            asynchronous active-low reset
//   req_i      in  P_NUM_PORTS  request vector
//   gnt_o      out P_NUM_PORTS  one-hot grant (combinational)
//   gnt_idx_o  out IDX_W        binary index of the granted port
//   gnt_any_o  out 1            a grant was issued this cycle
// -----------------------------------------------------------------------------
module mac_lookup_table_rr_arbiter #(
  parameter int P_NUM_PORTS = 4,
  parameter int IDX_W       = (P_NUM_PORTS > 1) ? $clog2(P_NUM_PORTS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [P_NUM_PORTS-1:0] req_i,
  output logic [P_NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]       gnt_idx_o,
  output logic                   gnt_any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    cand      = '0;
    // Walk ports starting at the pointer; the extra bit in cand absorbs the
    // wrap so non-power-of-two port counts rotate correctly.
    for (int k = 0; k < P_NUM_PORTS; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(P_NUM_PORTS)) begin
        cand = cand - (IDX_W+1)'(P_NUM_PORTS);
      end
      if (!gnt_any_o && req_i[cand[IDX_W-1:0]]) begin
        gnt_any_o                 = 1'b1;
        gnt_idx_o                 = cand[IDX_W-1:0];
        gnt_o[cand[IDX_W-1:0]]    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      ptr_d = (gnt_idx_o == IDX_W'(P_NUM_PORTS-1)) ? '0 : gnt_idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mac_lookup_table.sv
// -----------------------------------------------------------------------------
// mac_lookup_table
// Shared destination-MAC lookup engine for all RX ingress ports. Each port
// sends 1-cycle check pulses; requests are held per port, arbitrated
// round-robin, compared against a fully associative learned MAC->port table,
// and the result is strobed back to the requesting port only. Source MACs are
// learned through a separate strobe and entries age out when not re-learned.
// Ports:
//   i_clk          in  1               clock
//   i_rst_n        in  1               asynchronous active-low reset
//   i_check_mac    in  48*P_NUM_PORTS  dst MAC per port, slice p = [48p+47:48p]
//   i_check_id     in  4*P_NUM_PORTS   requester id per port
//   i_check_valid  in  P_NUM_PORTS     1-cycle request pulse per port
//   o_outport      out 4               lookup result port
//   o_check_id     out 4               echoed id of the serviced request
//   o_seek_flag    out 1               1 = hit, 0 = miss/broadcast (flood)
//   o_result_valid out P_NUM_PORTS     one-hot strobe to the serviced port
//   o_overrun      out P_NUM_PORTS     request overwrote a still-pending one
//   i_learn_valid  in  1               learn strobe
//   i_learn_mac    in  48              source MAC to learn
//   i_learn_port   in  4               port the source MAC arrived on
//   o_table_full   out 1               every table entry valid
// Latency: pulse in cycle T -> o_result_valid in cycle T+3 when uncontended.
// -----------------------------------------------------------------------------
module mac_lookup_table
  import mac_lookup_table_pkg::*;
#(
  parameter int          P_NUM_PORTS  = 4,
  parameter int          P_DEPTH      = 16,
  parameter logic [3:0]  P_FLOOD_PORT = FLOOD_PORT_DEFAULT,
  parameter logic [31:0] P_AGE_CYCLES = 32'd156_250_000
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [MAC_W*P_NUM_PORTS-1:0]  i_check_mac,
  input  logic [PORT_W*P_NUM_PORTS-1:0] i_check_id,
  input  logic [P_NUM_PORTS-1:0]        i_check_valid,
  output logic [PORT_W-1:0]             o_outport,
  output logic [PORT_W-1:0]             o_check_id,
  output logic                          o_seek_flag,
  output logic [P_NUM_PORTS-1:0]        o_result_valid,
  output logic [P_NUM_PORTS-1:0]        o_overrun,
  input  logic                          i_learn_valid,
  input  logic [MAC_W-1:0]              i_learn_mac,
  input  logic [PORT_W-1:0]             i_learn_port,
  output logic                          o_table_full
);

  localparam int PI_W = (P_NUM_PORTS > 1) ? $clog2(P_NUM_PORTS) : 1;
  localparam int TI_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

  // Request capture
  logic [P_NUM_PORTS-1:0] pend_q, pend_d;
  logic [P_NUM_PORTS-1:0] ovr_q, ovr_d;
  mac_t                   cap_mac_q [P_NUM_PORTS];
  port_t                  cap_id_q  [P_NUM_PORTS];

  // Arbitration
  logic [P_NUM_PORTS-1:0] gnt;
  logic [PI_W-1:0]        gnt_idx;
  logic                   gnt_any;

  // Pipeline
  logic                   vld_p1_q;
  logic [P_NUM_PORTS-1:0] gnt_p1_q;
  lkup_req_t              req_p1_q;
  logic                   lk_hit;
  port_t                  lk_port;
  logic [P_NUM_PORTS-1:0] vld_p2_q;
  port_t                  outport_p2_q;
  port_t                  id_p2_q;
  logic                   seek_p2_q;

  // Table
  logic [P_DEPTH-1:0]     tbl_vld_q, tbl_vld_d;
  logic [P_DEPTH-1:0]     tbl_age_q, tbl_age_d;
  mac_t                   tbl_mac_q  [P_DEPTH];
  port_t                  tbl_port_q [P_DEPTH];
  logic [TI_W-1:0]        victim_q, victim_d;
  logic [31:0]            age_cnt_q, age_cnt_d;
  logic                   age_tick;
  logic                   full_q;

  // Learn search
  logic                   lrn_ok, lrn_hit, lrn_free;
  logic [TI_W-1:0]        lrn_hit_idx, lrn_free_idx, lrn_idx;

  // ---------------------------------------------------------------------------
  // Stage p0: per-port request capture. A new pulse always wins over the grant
  // clearing the same bit; it only counts as an overrun when the older
  // request was not being granted in this very cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d = (pend_q & ~gnt) | i_check_valid;
    ovr_d  = i_check_valid & pend_q & ~gnt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int p = 0; p < P_NUM_PORTS; p++) begin
      if (i_check_valid[p]) begin
        cap_mac_q[p] <= i_check_mac[MAC_W*p +: MAC_W];
        cap_id_q[p]  <= i_check_id[PORT_W*p +: PORT_W];
      end
    end
  end

  mac_lookup_table_rr_arbiter #(
    .P_NUM_PORTS (P_NUM_PORTS),
    .IDX_W       (PI_W)
  ) u_arb (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .req_i     (pend_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // ---------------------------------------------------------------------------
  // Stage p1: granted request registered; compare runs against the table as it
  // stands this cycle, so a learn in the same cycle is not yet visible.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1_q <= 1'b0;
      gnt_p1_q <= '0;
    end else begin
      vld_p1_q <= gnt_any;
      gnt_p1_q <= gnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (gnt_any) begin
      req_p1_q.mac <= cap_mac_q[gnt_idx];
      req_p1_q.id  <= cap_id_q[gnt_idx];
    end
  end

  always_comb begin
    lk_hit  = 1'b0;
    lk_port = P_FLOOD_PORT;
    // Descending scan: the lowest matching index is written last and wins.
    for (int i = P_DEPTH-1; i >= 0; i--) begin
      if (tbl_vld_q[i] && (tbl_mac_q[i] == req_p1_q.mac)) begin
        lk_hit  = 1'b1;
        lk_port = tbl_port_q[i];
      end
    end
    if (mac_is_bcast(req_p1_q.mac)) begin
      lk_hit  = 1'b0;
      lk_port = P_FLOOD_PORT;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: registered result presented on the shared bus.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p2_q     <= '0;
      outport_p2_q <= '0;
      id_p2_q      <= '0;
      seek_p2_q    <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q ? gnt_p1_q : '0;
      if (vld_p1_q) begin
        outport_p2_q <= lk_port;
        id_p2_q      <= req_p1_q.id;
        seek_p2_q    <= lk_hit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Learning and aging. Slot choice: existing entry, else lowest free entry,
  // else the victim pointer. The aging tick is applied before the learn so a
  // learn coinciding with a tick leaves its entry valid with age set.
  // ---------------------------------------------------------------------------
  always_comb begin
    lrn_ok       = i_learn_valid && mac_learnable(i_learn_mac);
    lrn_hit      = 1'b0;
    lrn_hit_idx  = '0;
    lrn_free     = 1'b0;
    lrn_free_idx = '0;
    for (int i = P_DEPTH-1; i >= 0; i--) begin
      if (tbl_vld_q[i] && (tbl_mac_q[i] == i_learn_mac)) begin
        lrn_hit     = 1'b1;
        lrn_hit_idx = TI_W'(i);
      end
      if (!tbl_vld_q[i]) begin
        lrn_free     = 1'b1;
        lrn_free_idx = TI_W'(i);
      end
    end
    lrn_idx = lrn_hit ? lrn_hit_idx : (lrn_free ? lrn_free_idx : victim_q);

    // P_DEPTH is a power of two, so the victim pointer wraps by overflow.
    victim_d = victim_q;
    if (lrn_ok && !lrn_hit && !lrn_free) begin
      victim_d = victim_q + TI_W'(1);
    end

    age_tick  = (age_cnt_q == (P_AGE_CYCLES - 32'd1));
    age_cnt_d = age_tick ? '0 : age_cnt_q + 32'd1;

    tbl_vld_d = tbl_vld_q;
    tbl_age_d = tbl_age_q;
    if (age_tick) begin
      tbl_vld_d = tbl_vld_q & tbl_age_q;
      tbl_age_d = '0;
    end
    if (lrn_ok) begin
      tbl_vld_d[lrn_idx] = 1'b1;
      tbl_age_d[lrn_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tbl_vld_q <= '0;
      tbl_age_q <= '0;
      victim_q  <= '0;
      age_cnt_q <= '0;
      full_q    <= 1'b0;
    end else begin
      tbl_vld_q <= tbl_vld_d;
      tbl_age_q <= tbl_age_d;
      victim_q  <= victim_d;
      age_cnt_q <= age_cnt_d;
      full_q    <= &tbl_vld_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (lrn_ok) begin
      tbl_mac_q[lrn_idx]  <= i_learn_mac;
      tbl_port_q[lrn_idx] <= i_learn_port;
    end
  end

  assign o_outport      = outport_p2_q;
  assign o_check_id     = id_p2_q;
  assign o_seek_flag    = seek_p2_q;
  assign o_result_valid = vld_p2_q;
  assign o_overrun      = ovr_q;
  assign o_table_full   = full_q;

endmodule

// File: tb/tb_mac_lookup_table.sv
`timescale 1ns/1ps
module tb_mac_lookup_table;

  localparam int          NP  = 4;
  localparam logic [31:0] AGE = 32'd64;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [48*NP-1:0] chk_mac = '0;
  logic [4*NP-1:0]  chk_id  = '0;
  logic [NP-1:0]    chk_vld = '0;
  logic [3:0]       outport, out_id;
  logic             seek;
  logic [NP-1:0]    res_vld, ovr;
  logic             lrn_vld  = 1'b0;
  logic [47:0]      lrn_mac  = '0;
  logic [3:0]       lrn_port = '0;
  logic             full;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [NP-1:0] strobe;
    logic [3:0]    outport;
    logic [3:0]    id;
    logic          seek;
    int            at;
  } exp_t;
  exp_t expq[$];

  mac_lookup_table #(
    .P_NUM_PORTS  (NP),
    .P_DEPTH      (16),
    .P_FLOOD_PORT (4'd15),
    .P_AGE_CYCLES (AGE)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_check_mac    (chk_mac),
    .i_check_id     (chk_id),
    .i_check_valid  (chk_vld),
    .o_outport      (outport),
    .o_check_id     (out_id),
    .o_seek_flag    (seek),
    .o_result_valid (res_vld),
    .o_overrun      (ovr),
    .i_learn_valid  (lrn_vld),
    .i_learn_mac    (lrn_mac),
    .i_learn_port   (lrn_port),
    .o_table_full   (full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest outstanding expectation,
  // including the cycle in which it was expected.
  always @(negedge clk) begin
    exp_t e;
    if (res_vld != '0) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result strobe=%b id=%0d outport=%0d cyc=%0d required=no strobe",
                 res_vld, out_id, outport, cyc);
      end else begin
        e = expq.pop_front();
        if (res_vld !== e.strobe || outport !== e.outport || out_id !== e.id ||
            seek !== e.seek || cyc != e.at) begin
          failures++;
          $display("FAIL result actual strobe=%b outport=%0d id=%0d seek=%0b cyc=%0d required strobe=%b outport=%0d id=%0d seek=%0b cyc=%0d",
                   res_vld, outport, out_id, seek, cyc, e.strobe, e.outport, e.id, e.seek, e.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge clk);
      chk_vld = '0;
      lrn_vld = 1'b0;
    end
  endtask

  task automatic drive_chk(int p, logic [47:0] mac, logic [3:0] id);
    chk_mac[p*48 +: 48] = mac;
    chk_id[p*4 +: 4]    = id;
    chk_vld[p]          = 1'b1;
  endtask

  task automatic lookup(int p, logic [47:0] mac, logic [3:0] id,
                        logic [3:0] eport, logic eseek, int lat = 3);
    exp_t e;
    drive_chk(p, mac, id);
    e.strobe    = '0;
    e.strobe[p] = 1'b1;
    e.outport   = eport;
    e.id        = id;
    e.seek      = eseek;
    e.at        = cyc + lat;
    expq.push_back(e);
  endtask

  task automatic learn(logic [47:0] mac, logic [3:0] port);
    lrn_vld  = 1'b1;
    lrn_mac  = mac;
    lrn_port = port;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_result_valid"}, res_vld, 0);
    check({tag, "_outport"}, outport, 0);
    check({tag, "_check_id"}, out_id, 0);
    check({tag, "_seek"}, seek, 0);
    check({tag, "_overrun"}, ovr, 0);
    check({tag, "_table_full"}, full, 0);
  endtask

  task automatic apply_reset(string tag);
    @(negedge clk);
    rst_n   = 1'b0;
    chk_vld = '0;
    lrn_vld = 1'b0;
    #1;
    check_all_zero(tag);
    step(2);
    rst_n = 1'b1;
  endtask

  int r0;

  initial begin
    apply_reset("rst0");
    step(1);

    // Contention: all four ports in one cycle, served 0..3 on consecutive cycles.
    for (int p = 0; p < NP; p++) begin
      lookup(p, 48'h0A00_0000_0000 + 48'(p), 4'(4 + p), 4'd15, 1'b0, 3 + p);
    end
    step(9);

    // Overrun: port1 re-pulses while its first request still waits behind port0.
    lookup(0, 48'h0B00_0000_0000, 4'd1, 4'd15, 1'b0);
    drive_chk(1, 48'h0B00_0000_0001, 4'd2);
    step(1);
    check("overrun_none", ovr, 0);
    lookup(1, 48'h0B00_0000_0002, 4'd9, 4'd15, 1'b0);
    step(1);
    check("overrun_pulse", ovr, 4'b0010);
    step(1);
    check("overrun_clear", ovr, 0);
    step(6);

    // Miss on an empty table.
    lookup(0, 48'h0011_2233_4455, 4'd0, 4'd15, 1'b0);
    step(6);

    // Learn then hit.
    learn(48'h0011_2233_4455, 4'd2);
    step(1);
    lookup(1, 48'h0011_2233_4455, 4'd1, 4'd2, 1'b1);
    step(6);

    // Broadcast, group and zero MACs never hit; table keeps the unicast entry.
    lookup(2, 48'hFFFF_FFFF_FFFF, 4'd3, 4'd15, 1'b0);
    step(1);
    learn(48'h0100_5E00_0001, 4'd5);
    step(1);
    lookup(3, 48'h0100_5E00_0001, 4'd4, 4'd15, 1'b0);
    step(1);
    learn(48'h0, 4'd6);
    step(1);
    lookup(0, 48'h0, 4'd5, 4'd15, 1'b0);
    step(1);
    lookup(1, 48'h0011_2233_4455, 4'd6, 4'd2, 1'b1);
    step(6);

    // Re-learn of an existing MAC updates its port.
    learn(48'h0011_2233_4455, 4'd7);
    step(1);
    lookup(2, 48'h0011_2233_4455, 4'd7, 4'd7, 1'b1);
    step(6);

    // Learn landing on the compare edge is not seen; the next lookup hits.
    lookup(3, 48'hAABB_CC00_0001, 4'd8, 4'd15, 1'b0);
    step(2);
    learn(48'hAABB_CC00_0001, 4'd3);
    step(1);
    lookup(3, 48'hAABB_CC00_0001, 4'd9, 4'd3, 1'b1);
    step(6);

    // Fill, then replace: the 17th MAC evicts entry 0 (the first MAC).
    apply_reset("rst1");
    step(1);
    for (int i = 1; i <= 15; i++) begin
      learn(48'h0200_0000_0000 + 48'(i), 4'(i));
      step(1);
    end
    step(1);
    check("not_full_15", full, 0);
    learn(48'h0200_0000_0010, 4'd0);
    step(2);
    check("full_16", full, 1);
    learn(48'h0200_0000_0011, 4'd1);
    step(1);
    lookup(0, 48'h0200_0000_0001, 4'd1, 4'd15, 1'b0);
    step(1);
    lookup(1, 48'h0200_0000_0011, 4'd2, 4'd1, 1'b1);
    step(1);
    lookup(2, 48'h0200_0000_0002, 4'd3, 4'd2, 1'b1);
    step(1);
    lookup(3, 48'h0200_0000_0010, 4'd4, 4'd0, 1'b1);
    step(6);
    check("full_after_replace", full, 1);

    // Aging: survives the first tick, gone after the second.
    apply_reset("rst2");
    r0 = cyc;
    step(1);
    learn(48'h0A1B_2C3D_4E5F, 4'd6);
    step(1);
    lookup(0, 48'h0A1B_2C3D_4E5F, 4'd1, 4'd6, 1'b1);
    step(1);
    while (cyc < r0 + 80) step(1);
    lookup(1, 48'h0A1B_2C3D_4E5F, 4'd2, 4'd6, 1'b1);
    step(1);
    while (cyc < r0 + 150) step(1);
    lookup(2, 48'h0A1B_2C3D_4E5F, 4'd3, 4'd15, 1'b0);
    step(6);

    // Reset while lookups are in flight: no strobe may follow.
    drive_chk(0, 48'h0C00_0000_0001, 4'd4);
    step(1);
    drive_chk(1, 48'h0C00_0000_0002, 4'd5);
    step(1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    step(2);
    rst_n = 1'b1;
    step(8);

    check("scoreboard_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
